// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Access sizes, FSM states and the alignment/size error check.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // The reserved size encoding is reported the same way as a misaligned access.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr);
    case (size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = addr[0];
      SZ_W:    misaligned = |addr;
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store bus between the CPU datapath (master) and dmem_responder (slave).
interface dmem_responder_if;
  // Both channels: a transfer happens on a rising clk edge where valid && ready
  // are both high; the sender keeps valid and its payload stable until then.
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_byte_lanes.sv
// Lane steering: byte enables and replicated write data for stores, and
// down-shifted, zero-filled read data for loads.
module dmem_byte_lanes
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_word_i,
  output logic [3:0]  be_o,
  output logic [31:0] wword_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  assign shifted = rdata_word_i >> {lane_i, 3'b000};

  // Replicating the narrow store data puts it under every lane, so only the
  // byte enables depend on the address.
  always_comb begin
    be_o    = 4'b0000;
    wword_o = '0;
    rdata_o = '0;
    case (size_i)
      SZ_B: begin
        be_o    = 4'b0001 << lane_i;
        wword_o = {4{wdata_i[7:0]}};
        rdata_o = {24'b0, shifted[7:0]};
      end
      SZ_H: begin
        be_o    = 4'b0011 << lane_i;
        wword_o = {2{wdata_i[15:0]}};
        rdata_o = {16'b0, shifted[15:0]};
      end
      SZ_W: begin
        be_o    = 4'b1111;
        wword_o = wdata_i;
        rdata_o = rdata_word_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised RAM behind a valid/ready load/store
// bus, with a fixed access latency and lane-aligned read data.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus,
  output state_t           dbg_state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic [31:0]   mem_q [DEPTH];
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          req_ready_q;
  logic          resp_valid_q;
  logic          resp_err_q;
  logic [31:0]   resp_rdata_q;

  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          bad;
  logic          accept;
  logic [3:0]    be;
  logic [31:0]   wword;
  logic [31:0]   rdata_lane;
  logic          unused_addr_hi;

  // Upper address bits are ignored, so the RAM aliases every 4*DEPTH bytes.
  assign idx            = bus.req_addr[AW+1:2];
  assign lane           = bus.req_addr[1:0];
  assign unused_addr_hi = ^bus.req_addr[31:AW+2];
  assign bad            = misaligned(bus.req_size, lane);
  assign accept         = (state_q == IDLE) && bus.req_valid;

  dmem_byte_lanes u_lanes (
    .size_i       (bus.req_size),
    .lane_i       (lane),
    .wdata_i      (bus.req_wdata),
    .rdata_word_i (mem_q[idx]),
    .be_o         (be),
    .wword_o      (wword),
    .rdata_o      (rdata_lane)
  );

  // RAM has no reset; stores commit at the accept edge.
  always_ff @(posedge clk) begin
    if (!reset && accept && bus.req_we && !bad) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            req_ready_q  <= 1'b0;
            resp_err_q   <= bad;
            resp_rdata_q <= (bad || bus.req_we) ? 32'h0 : rdata_lane;
            if (LATENCY > 1) begin
              state_q <= WAIT;
              cnt_q   <= CW'(LATENCY - 1);
            end else begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (cnt_q == CW'(1)) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            cnt_q        <= '0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        RESP: begin
          // No re-accept here: the next request waits for IDLE.
          if (bus.resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign dbg_state_o    = state_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the far end of the CPU load/store interface.
- Accepts byte, half-word and word requests from the datapath/control, and serves them from an internal word-organised RAM.
- Applies a configurable access latency and returns lane-aligned read data, so the existing sign/zero-extension logic in the datapath works unchanged.
- Uses a valid/ready handshake on both request and response.

Parameters:
- DEPTH, 256: number of 32-bit words; power of two.
- LATENCY, 1: cycles from request acceptance to resp_valid; must be at least 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half-word, 10 word, 11 reserved (error).
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-justified: a byte uses [7:0], a half-word uses [15:0].
- resp_valid  output  1  response present.
- resp_ready  input  1  requester takes the response.
- resp_rdata  output  32  load data, shifted to bit 0 and zero-filled above the access size; 0 for stores and errors.
- resp_err  output  1  misaligned access or reserved size.

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0; state=IDLE; latency counter=0.
- RAM contents are not affected by reset.
- States:
  - IDLE: req_ready=1. On req_valid, the request is accepted at that edge. Go to WAIT if LATENCY>1, otherwise go to RESP.
  - WAIT: req_ready=0. The counter loads LATENCY-1 on accept and decrements each cycle. Go to RESP when the count reaches 1.
  - RESP: req_ready=0, resp_valid=1, resp_rdata and resp_err held stable. On resp_ready, return to IDLE. There is no same-cycle re-accept, so the next request can be accepted in the cycle after the handshake.
- Latency: a request accepted at edge t gives resp_valid high from cycle t+LATENCY, and it stays high until resp_ready.
- Address decode:
  - Word index = req_addr[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses alias modulo 4*DEPTH.
  - Lane = req_addr[1:0].
- Alignment: a half-word needs addr[0]=0; a word needs addr[1:0]=00. A violation or size 11 gives resp_err=1, resp_rdata=0, and the RAM is not written. The response still follows the normal latency.
- Store: commits at the accept edge.
  - Byte enables: byte = 1 bit at the lane; half-word = 2 bits at the lane; word = all 4.
  - Write data is replicated or shifted into the enabled lanes. Unenabled bytes keep their old value.
- Load: the word is read at the accept edge, then the lane is shifted down and zero-filled above the access size.
  - Byte at lane 3 returns {24'b0, mem[31:24]}.
  - Half-word at lane 2 returns {16'b0, mem[31:16]}.
- Read-after-write: a load accepted after a store's handshake sees the stored data. A single request is outstanding at a time, so no hazards exist.
- Inputs are sampled only at the accept edge. Changes to req_* while the responder is busy are ignored.
- Reset mid-operation: the state is forced to IDLE and resp_valid is dropped next cycle; the pending response is discarded. A store already accepted stays committed.
- req_valid and resp_ready may both be high in RESP. Only the response handshake completes in that cycle.

Decomposition:
- Package dmem_pkg holds:
  - typedef enum for size {SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10};
  - typedef enum for state {IDLE, WAIT, RESP};
  - function misaligned(size, addr[1:0]).
- Sub-module dmem_byte_lanes: combinational.
  - Inputs: size, lane, wdata, rdata_word.
  - Outputs: byte-enable[3:0], shifted write word, extracted read data.
  - The top level holds the FSM, counter, RAM and output registers.

Test Plan:
- Word store/load: store word 0xDEADBEEF at 0x10, then load word at 0x10 with LATENCY=1. Expect resp_rdata=0xDEADBEEF and resp_err=0, with resp_valid exactly 1 cycle after accept.
- Byte lanes: after the first test, store byte 0x5A at 0x12, then load word 0x10. Expect 0xDE5ABEEF. Load byte 0x13 and expect 0x000000DE.
- Half-word: store half-word 0x8001 at 0x22, then load half-word 0x22. Expect 0x00008001, and word 0x20 has [31:16]=0x8001 with the low half unchanged.
- Errors: load half-word at 0x11, load word at 0x12, and size 11. Expect resp_err=1 and resp_rdata=0. A store word at 0x13 must leave mem[0x10] unchanged.
- Latency/backpressure: with LATENCY=4, expect req_ready=0 for 4 cycles after accept. Hold resp_ready=0 for 3 cycles after resp_valid; resp_valid and resp_rdata must stay stable, and req_ready rises the cycle after resp_ready.
- Reset mid-flight: LATENCY=3, accept a store of 0x11223344 at 0x40, then assert reset 1 cycle later. Expect resp_valid never asserts and req_ready=1 after reset. A later load at 0x40 returns 0x11223344.
